// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder: multi-cycle load/store responder with programmable wait states and pipeline stall.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of force-aligning them.
module mips_dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        err_o
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               we_q, sgn_q;
    logic [1:0]         size_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic               rv_q, err_q;
    logic [31:0]        rdata_q;
    logic [31:0]        mem_q [2**ADDR_W];

    logic               do_acc, mis, a_we, a_sgn;
    logic [1:0]         a_size;
    logic [ADDR_W+1:0]  a_addr;
    logic [31:0]        a_wdata, rd_word, sh, ld, wd;
    logic [3:0]         be;
    logic [4:0]         sa;
    logic               unused_addr;

    assign unused_addr = ^req_addr_i[31:ADDR_W+2];

    // With zero wait states the access happens on the acceptance edge, so use the live inputs in IDLE.
    assign a_we    = state_q == IDLE ? req_we_i : we_q;
    assign a_sgn   = state_q == IDLE ? req_signed_i : sgn_q;
    assign a_size  = state_q == IDLE ? req_size_i : size_q;
    assign a_addr  = state_q == IDLE ? req_addr_i[ADDR_W+1:0] : addr_q;
    assign a_wdata = state_q == IDLE ? req_wdata_i : wdata_q;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis = (a_size == 2'd1 && a_addr[0]) || (a_size[1] && a_addr[1:0] != 2'd0);
`else
    assign mis = 1'b0;
`endif

    assign be = a_size[1] ? 4'hF : a_size[0] ? (a_addr[1] ? 4'hC : 4'h3) : 4'(4'h1 << a_addr[1:0]);
    assign wd = a_size[1] ? a_wdata : a_size[0] ? {2{a_wdata[15:0]}} : {4{a_wdata[7:0]}};
    assign sa = a_size[1] ? 5'd0 : a_size[0] ? {a_addr[1], 4'b0} : {a_addr[1:0], 3'b0};
    assign rd_word = mem_q[a_addr[ADDR_W+1:2]];
    assign sh = rd_word >> sa;
    assign ld = a_size[1] ? sh :
                a_size[0] ? {{16{a_sgn & sh[15]}}, sh[15:0]} : {{24{a_sgn & sh[7]}}, sh[7:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_acc  = 1'b0;
        case (state_q)
            IDLE: if (req_valid_i) begin
                cnt_d   = WC;
                do_acc  = WC == 4'd0;
                state_d = WC == 4'd0 ? RESP : WAIT;
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                do_acc  = cnt_q == 4'd1;
                state_d = cnt_q == 4'd1 ? RESP : WAIT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign stall_o      = (state_q != IDLE && state_q != RESP) || (state_q == IDLE && req_valid_i);
    assign resp_valid_o = rv_q;
    assign resp_rdata_o = rdata_q;
    assign err_o        = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rv_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rv_q    <= do_acc;
            rdata_q <= do_acc && !a_we && !mis ? ld : 32'd0;
            err_q   <= do_acc && mis;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && req_valid_i) begin
            we_q    <= req_we_i;
            sgn_q   <= req_signed_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i[ADDR_W+1:0];
            wdata_q <= req_wdata_i;
        end
    end

    // Memory has no reset; an access aborted by reset never commits.
    always_ff @(posedge clk) begin
        if (!rst && do_acc && a_we && !mis)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem_q[a_addr[ADDR_W+1:2]][8*i+:8] <= wd[8*i+:8];
    end
endmodule
